// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per RUN cycle, sign correction and HI/LO write-back in FIX.
module mdu_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, stateNext;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc, mq, dvs;
   logic             negQ, negR, isDiv;

   logic             startOp, mtHi, mtLo, iterate, writeRes;
   logic             signedOp;
   logic [WIDTH-1:0] mag1, mag2;
   logic [WIDTH:0]   mulSum, divShift;
   logic [WIDTH-1:0] divSub, divRem;
   logic             divGe;
   logic [2*WIDTH-1:0] prod, prodRes;
   logic [WIDTH-1:0] resHi, resLo;

   // State register; busy/done are registered decodes of the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= stateNext;
         busy  <= (stateNext == RUN);
         done  <= (stateNext == FIX);
      end
   end

   // Next-state and control decode
   always_comb begin
      stateNext = state;
      startOp   = 1'b0;
      mtHi      = 1'b0;
      mtLo      = 1'b0;
      iterate   = 1'b0;
      writeRes  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !flush) begin
               startOp = !op[2];
               mtHi    = (op == OP_MTHI);
               mtLo    = (op == OP_MTLO);
               if (!op[2]) stateNext = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               stateNext = IDLE;
            end else begin
               iterate = 1'b1;
               if (count == CW'(1)) stateNext = FIX;
            end
         end
         FIX: begin
            writeRes  = !flush;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Operand magnitudes and one iteration step of each algorithm
   always_comb begin
      signedOp = !op[0];
      mag1     = (signedOp && in1[WIDTH-1]) ? (~in1 + WIDTH'(1)) : in1;
      mag2     = (signedOp && in2[WIDTH-1]) ? (~in2 + WIDTH'(1)) : in2;
      mulSum   = {1'b0, acc} + (mq[0] ? {1'b0, dvs} : (WIDTH+1)'(0));
      divShift = {acc, mq[WIDTH-1]};
      divGe    = (divShift >= {1'b0, dvs});
      divSub   = divShift[WIDTH-1:0] - dvs;
      divRem   = divGe ? divSub : divShift[WIDTH-1:0];
   end

   // Sign correction of the finished magnitudes
   always_comb begin
      prod    = {acc, mq};
      prodRes = negQ ? (~prod + (2*WIDTH)'(1)) : prod;
      if (isDiv) begin
         resLo = negQ ? (~mq + WIDTH'(1)) : mq;
         resHi = negR ? (~acc + WIDTH'(1)) : acc;
      end else begin
         resLo = prodRes[WIDTH-1:0];
         resHi = prodRes[2*WIDTH-1:WIDTH];
      end
   end

   // Datapath and architectural HI/LO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         acc   <= '0;
         mq    <= '0;
         dvs   <= '0;
         negQ  <= 1'b0;
         negR  <= 1'b0;
         isDiv <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         if (startOp) begin
            isDiv <= op[1];
            negQ  <= signedOp && (in1[WIDTH-1] ^ in2[WIDTH-1]);
            negR  <= signedOp && in1[WIDTH-1];
            acc   <= '0;
            mq    <= op[1] ? mag1 : mag2;
            dvs   <= op[1] ? mag2 : mag1;
            count <= CW'(WIDTH);
         end else if (iterate) begin
            count <= count - CW'(1);
            if (isDiv) begin
               acc <= divRem;
               mq  <= {mq[WIDTH-2:0], divGe};
            end else begin
               acc <= mulSum[WIDTH:1];
               mq  <= {mulSum[0], mq[WIDTH-1:1]};
            end
         end
         if (mtHi) hi <= in1;
         if (mtLo) lo <= in1;
         if (writeRes) begin
            hi <= resHi;
            lo <= resLo;
         end
      end
   end

endmodule
